// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetches 32-bit instructions from instruction memory starting at the PC
//   loaded by the PC register, buffers them in a small prefetch FIFO and hands
//   them to decode over a valid/ready handshake. A redirect (pc_load) flushes
//   the FIFO and any in-flight fetch so stale instructions never reach decode.
//
// Ports
//   clock, reset_n            rising-edge clock, async active-low reset
//   pc_in, pc_load            redirect target and strobe
//   imem_req/addr/ack/rdata   instruction memory req/ack interface
//   if_valid/ready/instr/pc   decode-side handshake and head entry
module instr_fetch_unit #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_load,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  state_e                    state_q;
  logic [ADDR_W-1:0]         fetch_addr_q;
  logic [ADDR_W-1:0]         redirect_addr_q;
  entry_t [FIFO_DEPTH-1:0]   mem_q;
  logic [PTR_W-1:0]          wr_q, rd_q;
  logic [CNT_W-1:0]          cnt_q;

  logic [ADDR_W-1:0] pc_al;
  logic              hs, flush, push, pop;
  entry_t            head;

  assign pc_al = pc_in & ~ADDR_W'(3);

  // Request stays up in DROP regardless of FIFO level: the old transfer must
  // be allowed to complete before the redirected fetch can start.
  assign imem_req  = ((state_q == FETCH) && (cnt_q < CNT_W'(FIFO_DEPTH))) ||
                     (state_q == DROP);
  assign imem_addr = fetch_addr_q;

  assign hs    = imem_req && imem_ack;
  assign flush = pc_load;
  assign push  = (state_q == FETCH) && hs && !pc_load;
  // A beat shown during a flush cycle is discarded, not consumed.
  assign pop   = if_valid && if_ready && !flush;

  assign head     = mem_q[rd_q];
  assign if_valid = (cnt_q != '0);
  assign if_instr = head.instr;
  assign if_pc    = head.pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      fetch_addr_q    <= '0;
      redirect_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pc_load) begin
            fetch_addr_q <= pc_al;
            state_q      <= FETCH;
          end
        end
        FETCH: begin
          if (pc_load) begin
            // Pending request with no ack yet: park the target and drain it.
            if (imem_req && !imem_ack) begin
              redirect_addr_q <= pc_al;
              state_q         <= DROP;
            end else begin
              fetch_addr_q <= pc_al;
            end
          end else if (hs) begin
            fetch_addr_q <= fetch_addr_q + ADDR_W'(4);
          end
        end
        DROP: begin
          if (hs) begin
            fetch_addr_q <= pc_load ? pc_al : redirect_addr_q;
            state_q      <= FETCH;
          end else if (pc_load) begin
            redirect_addr_q <= pc_al;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= '{pc: fetch_addr_q, instr: imem_rdata};
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_load;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 0;
  int wcnt    = 0;
  bit force_ack = 1'b0;
  logic [ADDR_W+DATA_W-1:0] beat_q[$];

  always #5 clock = ~clock;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .pc_in(pc_in), .pc_load(pc_load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  function automatic logic [DATA_W-1:0] md(input logic [ADDR_W-1:0] a);
    return {20'hDA7A0, a};
  endfunction

  // memory model: ack after 'lat' wait cycles of a held request
  assign imem_ack   = force_ack | (imem_req && (wcnt >= lat));
  assign imem_rdata = md(imem_addr);
  always @(posedge clock) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  // decode-side monitor: accepted beats (a flush-cycle beat is not consumed)
  always @(negedge clock) begin
    if (reset_n && if_valid && if_ready && !pc_load)
      beat_q.push_back({if_pc, if_instr});
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; pc_load = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [ADDR_W-1:0] pc);
    logic [ADDR_W+DATA_W-1:0] b;
    b = (i < beat_q.size()) ? beat_q[i] : '1;
    chk(tag, b, {pc, md(pc)});
  endtask

  initial begin
    reset_n = 1'b0; pc_load = 1'b0; pc_in = '0; if_ready = 1'b0;
    step(); step();
    @(negedge clock);
    chk("rst req",   imem_req, 0);
    chk("rst addr",  imem_addr, 0);
    chk("rst valid", if_valid, 0);
    chk("rst instr", if_instr, 0);
    chk("rst pc",    if_pc, 0);
    reset_n = 1'b1;

    // sequential fetch, zero-wait memory
    lat = 0; if_ready = 1'b1;
    step(); pc_load = 1'b1; pc_in = 12'h100;          // N
    step(); pc_load = 1'b0;                            // N+1
    @(negedge clock);
    chk("seq req",  imem_req, 1);
    chk("seq addr", imem_addr, 12'h100);
    chk("seq v0",   if_valid, 0);
    step(); @(negedge clock);                          // N+2
    chk("seq valid", if_valid, 1);
    chk("seq pc0",   if_pc, 12'h100);
    chk("seq in0",   if_instr, md(12'h100));
    step(); @(negedge clock);                          // N+3
    chk("seq pc1",   if_pc, 12'h104);
    chk("seq in1",   if_instr, md(12'h104));
    step(); @(negedge clock);                          // N+4
    chk("seq pc2",   if_pc, 12'h108);

    // backpressure
    step(); if_ready = 1'b0;                           // N+5
    step(); @(negedge clock);                          // N+6
    chk("bp full req", imem_req, 0);
    chk("bp head",     if_pc, 12'h10C);
    repeat (4) step();                                 // N+10
    @(negedge clock);
    chk("bp hold req", imem_req, 0);
    chk("bp hold vld", if_valid, 1);
    chk("bp hold pc",  if_pc, 12'h10C);
    step(); if_ready = 1'b1; beat_q.delete();          // N+11
    repeat (4) step();                                 // N+15
    if_ready = 1'b0;
    chk("bp nbeats", beat_q.size(), 4);
    chk_beat("bp b0", 0, 12'h10C);
    chk_beat("bp b1", 1, 12'h110);
    chk_beat("bp b2", 2, 12'h114);
    chk_beat("bp b3", 3, 12'h118);

    // redirect while a slow request is pending
    do_reset(); lat = 3; if_ready = 1'b1;
    step(); pc_load = 1'b1; pc_in = 12'h100;          // M
    step(); pc_load = 1'b0;                            // M+1
    repeat (5) step();                                 // M+6
    pc_load = 1'b1; pc_in = 12'h040;
    @(negedge clock);
    chk("rd pend addr", imem_addr, 12'h104);
    step(); pc_load = 1'b0; beat_q.delete();           // M+7
    @(negedge clock);
    chk("rd drop req",  imem_req, 1);
    chk("rd drop addr", imem_addr, 12'h104);
    chk("rd flushed",   if_valid, 0);
    step(); @(negedge clock);                          // M+8 (ack)
    chk("rd ack addr",  imem_addr, 12'h104);
    step(); @(negedge clock);                          // M+9
    chk("rd new req",   imem_req, 1);
    chk("rd new addr",  imem_addr, 12'h040);
    repeat (6) step();                                 // M+15
    chk("rd nbeats", beat_q.size(), 1);
    chk_beat("rd b0", 0, 12'h040);

    // double redirect while draining
    do_reset(); lat = 3; if_ready = 1'b1;
    step(); pc_load = 1'b1; pc_in = 12'h100;          // P
    step(); pc_load = 1'b0;                            // P+1
    step(); pc_load = 1'b1; pc_in = 12'h200;          // P+2
    step(); pc_in = 12'h300;                           // P+3
    step(); pc_load = 1'b0; beat_q.delete();           // P+4 (ack)
    step(); @(negedge clock);                          // P+5
    chk("dr addr", imem_addr, 12'h300);
    repeat (5) step();                                 // P+10
    chk("dr nbeats", beat_q.size(), 1);
    chk_beat("dr b0", 0, 12'h300);

    // wrap and alignment
    do_reset(); lat = 0; if_ready = 1'b1;
    step(); pc_load = 1'b1; pc_in = 12'hFFE;          // W
    step(); pc_load = 1'b0; @(negedge clock);          // W+1
    chk("wr addr0", imem_addr, 12'hFFC);
    step(); @(negedge clock);                          // W+2
    chk("wr addr1", imem_addr, 12'h000);
    chk("wr pc0",   if_pc, 12'hFFC);
    step(); @(negedge clock);                          // W+3
    chk("wr pc1",   if_pc, 12'h000);
    chk("wr in1",   if_instr, md(12'h000));

    // async reset during a pending request
    do_reset(); lat = 3; if_ready = 1'b0;
    step(); pc_load = 1'b1; pc_in = 12'h100;          // R
    step(); pc_load = 1'b0;                            // R+1
    repeat (5) step();                                 // R+6
    chk("ar pre vld", if_valid, 1);
    chk("ar pre req", imem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar req",   imem_req, 0);
    chk("ar addr",  imem_addr, 0);
    chk("ar valid", if_valid, 0);
    chk("ar instr", if_instr, 0);
    chk("ar pc",    if_pc, 0);
    force_ack = 1'b1;
    step(); reset_n = 1'b1;
    step(); step(); @(negedge clock);
    chk("ar late req",   imem_req, 0);
    chk("ar late valid", if_valid, 0);
    chk("ar late addr",  imem_addr, 0);
    force_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Reads the program counter produced by the PC register and fetches the addressed 32-bit instructions from instruction memory over a req/ack handshake.
- Fetched instructions are buffered in a small prefetch FIFO and presented to the decode stage with a valid/ready handshake.
- Sits between the PC register/address mux and decode.
- Handles redirects (branch/jump/reset vector) by flushing buffered and in-flight fetches.

## Interface
- ADDR_W, 12, byte address width; matches the PC register width.
- DATA_W, 32, instruction width.
- FIFO_DEPTH, 2, prefetch entries; power of two, at least 2.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- pc_in  in  ADDR_W  PC value from the PC register; sampled only when pc_load=1.
- pc_load  in  1  redirect strobe: restart fetch at pc_in.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch byte address; bits [1:0] always 00.
- imem_ack  in  1  request complete; imem_rdata is valid this cycle.
- imem_rdata  in  DATA_W  instruction data.
- if_valid  out  1  if_instr/if_pc are valid.
- if_ready  in  1  decode accepts the head entry.
- if_instr  out  DATA_W  head instruction.
- if_pc  out  ADDR_W  address of the head instruction.

## Operation
- State: FSM {IDLE, FETCH, DROP}; fetch_addr register; redirect_addr register; FIFO of {pc, instr}, FIFO_DEPTH entries, with a count.
- Reset values:
  - State is IDLE; fetch_addr, redirect_addr and FIFO pointers/count are 0.
  - imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0.
- Address alignment: pc_in[1:0] are ignored (forced to 00). Increment is +4 modulo 2^ADDR_W, so 0xFFC wraps to 0x000.
- imem_req is asserted when (state==FETCH and count<FIFO_DEPTH) or state==DROP.
- imem_addr = fetch_addr.
- Once raised, imem_req and imem_addr hold stable until imem_ack.
- A handshake completes when imem_req and imem_ack are both high in the same cycle. imem_ack with imem_req=0 is ignored.
- IDLE:
  - Requests nothing.
  - pc_load: fetch_addr<=pc_in, go to FETCH.
- FETCH, no pc_load:
  - Handshake: push {fetch_addr, imem_rdata}, fetch_addr<=fetch_addr+4.
- FETCH with pc_load:
  - Always flush the FIFO.
  - With a handshake in the same cycle: discard the data, fetch_addr<=pc_in, stay in FETCH.
  - imem_req=1 and no ack: redirect_addr<=pc_in, go to DROP.
  - imem_req=0 (FIFO full): fetch_addr<=pc_in, stay in FETCH.
- DROP:
  - Keeps the old request alive until it completes.
  - pc_load without ack: redirect_addr<=pc_in (latest redirect wins).
  - On handshake: discard the data; fetch_addr<=(pc_load ? pc_in : redirect_addr); go to FETCH.
- Output side:
  - if_valid = (count!=0); if_instr/if_pc come from the FIFO head.
  - Pop when if_valid and if_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - Flush has priority over both push and pop. The entry decode sees in a flush cycle is not counted as consumed.
- No instruction fetched before a redirect may appear on if_* after the redirect cycle.

## Timing
- pc_load at cycle N: imem_req=1 with imem_addr=pc_in&~3 at N+1.
- With a zero-wait ack at N+1: if_valid=1 at N+2.
- Throughput is one instruction per cycle with zero-wait memory and if_ready held high.
- if_ready low: at most FIFO_DEPTH instructions are buffered, then imem_req drops combinationally in the cycle count reaches FIFO_DEPTH.
- Flush takes effect on the clock edge of the pc_load cycle: if_valid=0 in the next cycle.
- reset_n assertion mid-transfer clears everything immediately. Any later imem_ack from that request is ignored, since imem_req is 0.

## Test plan
- Sequential fetch: reset; pc_load with pc_in=0x100; zero-wait ack; if_ready=1.
  - Required: if_pc sequence 0x100, 0x104, 0x108, one per cycle starting 2 cycles after pc_load, with if_instr equal to the memory model data.
- Backpressure: if_ready=0 for 6 cycles.
  - Required: exactly 2 entries buffered, imem_req low while full, order preserved when if_ready rises, no duplicates and no drops.
- Redirect mid-request: memory acks with 3-cycle latency; pc_load with pc_in=0x040 while the request for 0x104 is pending.
  - Required: imem_addr stays 0x104 until ack, that data never appears on if_*, and the next request is 0x040.
- Double redirect in DROP: pc_load 0x200, then pc_load 0x300 before the ack.
  - Required: the first instruction delivered has if_pc=0x300.
- Wrap and alignment: pc_load with pc_in=0xFFE.
  - Required: fetch addresses 0xFFC, then 0x000.
- Async reset during a pending request: drive reset_n low between clock edges.
  - Required: all outputs go to 0 immediately, and a later ack has no effect.
